// File: rtl/wb_stage_if.sv
// Writeback stage bus bundle: memory-stage handoff, register file write port
// and difftest commit record. The stage uses the slave side; whoever drives
// the memory-stage fields and consumes the outputs uses the master side.
interface wb_stage_if #(
  parameter int XLEN  = 64,
  parameter int RAW   = 5,
  parameter int CNT_W = 64
);
  // memory stage -> writeback
  logic            mem_valid_i;
  logic            mem_ready_o;
  logic [63:0]     mem_pc_i;
  logic [31:0]     mem_inst_i;
  logic            mem_rd_we_i;
  logic [RAW-1:0]  mem_rd_addr_i;
  logic [XLEN-1:0] mem_alu_res_i;
  logic            mem_is_load_i;
  logic [2:0]      mem_funct3_i;
  logic [XLEN-1:0] mem_rdata_i;
  // register file write port
  logic            we_o;
  logic [RAW-1:0]  waddr_o;
  logic [XLEN-1:0] wdata_o;
  // difftest commit record
  logic             diff_ready_i;
  logic             commit_valid_o;
  logic [63:0]      commit_pc_o;
  logic [31:0]      commit_inst_o;
  logic [CNT_W-1:0] commit_cnt_o;
  logic             halt_o;

  modport slave (
    input  mem_valid_i, mem_pc_i, mem_inst_i, mem_rd_we_i, mem_rd_addr_i,
           mem_alu_res_i, mem_is_load_i, mem_funct3_i, mem_rdata_i, diff_ready_i,
    output mem_ready_o, we_o, waddr_o, wdata_o, commit_valid_o, commit_pc_o,
           commit_inst_o, commit_cnt_o, halt_o
  );

  modport master (
    output mem_valid_i, mem_pc_i, mem_inst_i, mem_rd_we_i, mem_rd_addr_i,
           mem_alu_res_i, mem_is_load_i, mem_funct3_i, mem_rdata_i, diff_ready_i,
    input  mem_ready_o, we_o, waddr_o, wdata_o, commit_valid_o, commit_pc_o,
           commit_inst_o, commit_cnt_o, halt_o
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: single-entry MEM/WB buffer, load data extraction,
// register file write, difftest commit record and sticky ebreak halt.
module wb_stage #(
  parameter int XLEN  = 64,
  parameter int RAW   = 5,
  parameter int CNT_W = 64
) (
  input logic      clk,
  input logic      rst,
  wb_stage_if.slave wb
);
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_HALTED} state_t;

  state_t           state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic             rd_we_q, rd_we_d;
  logic [RAW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0]  alu_q, alu_d;
  logic             is_load_q, is_load_d;
  logic [2:0]       f3_q, f3_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            valid, ready, acc, ret, held_ebreak;
  logic [XLEN-1:0] sh, ld_data;

  // Handshake decode; a held ebreak blocks intake so nothing is accepted
  // behind it and then silently lost when the stage halts.
  always_comb begin
    valid       = (state_q == S_FULL);
    held_ebreak = valid & (inst_q == EBREAK);
    ready       = (state_q != S_HALTED) & (!valid | wb.diff_ready_i) & !held_ebreak;
    acc         = wb.mem_valid_i & ready;
    ret         = valid & wb.diff_ready_i;
  end

  // Next-state: retire empties (or halts on ebreak), accept overwrites the slot.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    rd_we_d   = rd_we_q;
    rd_d      = rd_q;
    alu_d     = alu_q;
    is_load_d = is_load_q;
    f3_d      = f3_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    if (ret) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = held_ebreak ? S_HALTED : S_EMPTY;
    end
    if (acc) begin
      state_d   = S_FULL;
      pc_d      = wb.mem_pc_i;
      inst_d    = wb.mem_inst_i;
      rd_we_d   = wb.mem_rd_we_i;
      rd_d      = wb.mem_rd_addr_i;
      alu_d     = wb.mem_alu_res_i;
      is_load_d = wb.mem_is_load_i;
      f3_d      = wb.mem_funct3_i;
      rdata_d   = wb.mem_rdata_i;
    end
  end

  // State machine and captured entry; HALTED is left only through reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_EMPTY;
      pc_q      <= '0;
      inst_q    <= '0;
      rd_we_q   <= 1'b0;
      rd_q      <= '0;
      alu_q     <= '0;
      is_load_q <= 1'b0;
      f3_q      <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      rd_we_q   <= rd_we_d;
      rd_q      <= rd_d;
      alu_q     <= alu_d;
      is_load_q <= is_load_d;
      f3_q      <= f3_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  // Load extraction from the raw aligned doubleword; the byte offset is
  // taken as-is, so misaligned accesses just see the shifted-in zeros.
  always_comb begin
    sh = rdata_q >> {alu_q[2:0], 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{(XLEN-8){sh[7]}},   sh[7:0]};
      3'b001:  ld_data = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b010:  ld_data = {{(XLEN-32){sh[31]}}, sh[31:0]};
      3'b011:  ld_data = sh;
      3'b100:  ld_data = {{(XLEN-8){1'b0}},    sh[7:0]};
      3'b101:  ld_data = {{(XLEN-16){1'b0}},   sh[15:0]};
      3'b110:  ld_data = {{(XLEN-32){1'b0}},   sh[31:0]};
      default: ld_data = '0;
    endcase
  end

  assign wb.mem_ready_o    = ready;
  assign wb.we_o           = ret & rd_we_q & (rd_q != '0);
  assign wb.waddr_o        = rd_q;
  assign wb.wdata_o        = is_load_q ? ld_data : alu_q;
  assign wb.commit_valid_o = valid;
  assign wb.commit_pc_o    = pc_q;
  assign wb.commit_inst_o  = inst_q;
  assign wb.commit_cnt_o   = cnt_q;
  assign wb.halt_o         = (state_q == S_HALTED);
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: inputs change on the falling edge, outputs
// are checked 1 time unit later, well before the next rising edge.
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  wb_stage_if #(.XLEN(64), .RAW(5), .CNT_W(64)) w ();

  wb_stage #(.XLEN(64), .RAW(5), .CNT_W(64)) dut (
    .clk(clk),
    .rst(rst),
    .wb (w.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [63:0] pc, input logic [31:0] inst, input logic rd_we,
                       input logic [4:0] rd, input logic [63:0] alu, input logic is_load,
                       input logic [2:0] f3, input logic [63:0] rdata);
    w.mem_valid_i   = 1'b1;
    w.mem_pc_i      = pc;
    w.mem_inst_i    = inst;
    w.mem_rd_we_i   = rd_we;
    w.mem_rd_addr_i = rd;
    w.mem_alu_res_i = alu;
    w.mem_is_load_i = is_load;
    w.mem_funct3_i  = f3;
    w.mem_rdata_i   = rdata;
  endtask

  task automatic idle();
    w.mem_valid_i = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " ready"},  64'(w.mem_ready_o),    64'd1);
    chk({tag, " we"},     64'(w.we_o),           64'd0);
    chk({tag, " waddr"},  64'(w.waddr_o),        64'd0);
    chk({tag, " wdata"},  w.wdata_o,             64'd0);
    chk({tag, " cvalid"}, 64'(w.commit_valid_o), 64'd0);
    chk({tag, " cpc"},    w.commit_pc_o,         64'd0);
    chk({tag, " cinst"},  64'(w.commit_inst_o),  64'd0);
    chk({tag, " cnt"},    w.commit_cnt_o,        64'd0);
    chk({tag, " halt"},   64'(w.halt_o),         64'd0);
  endtask

  localparam logic [63:0] RDATA  = 64'h8877_6655_4433_2211;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ADDI   = 32'h0000_0013;

  logic [2:0]  ld_off [6];
  logic [2:0]  ld_f3  [6];
  logic [63:0] ld_exp [6];

  initial begin
    ld_off[0] = 3'd7; ld_f3[0] = 3'b000; ld_exp[0] = 64'hFFFF_FFFF_FFFF_FF88; // lb
    ld_off[1] = 3'd6; ld_f3[1] = 3'b101; ld_exp[1] = 64'h0000_0000_0000_8877; // lhu
    ld_off[2] = 3'd4; ld_f3[2] = 3'b010; ld_exp[2] = 64'hFFFF_FFFF_8877_6655; // lw
    ld_off[3] = 3'd0; ld_f3[3] = 3'b011; ld_exp[3] = 64'h8877_6655_4433_2211; // ld
    ld_off[4] = 3'd1; ld_f3[4] = 3'b100; ld_exp[4] = 64'h0000_0000_0000_0022; // lbu
    ld_off[5] = 3'd2; ld_f3[5] = 3'b111; ld_exp[5] = 64'h0;                   // reserved

    w.diff_ready_i = 1'b1;
    offer(64'h0, 32'h0, 1'b0, 5'd0, 64'h0, 1'b0, 3'd0, 64'h0);
    idle();

    // reset state
    #2;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // back-to-back ALU ops
    @(negedge clk);
    offer(64'h100, ADDI, 1'b1, 5'd5, 64'h1234, 1'b0, 3'd0, 64'h0);
    @(negedge clk);
    offer(64'h104, ADDI, 1'b1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd0, 64'h0);
    #1;
    chk("b2b0 we",    64'(w.we_o),        64'd1);
    chk("b2b0 waddr", 64'(w.waddr_o),     64'd5);
    chk("b2b0 wdata", w.wdata_o,          64'h1234);
    chk("b2b0 cpc",   w.commit_pc_o,      64'h100);
    chk("b2b0 cnt",   w.commit_cnt_o,     64'd0);
    chk("b2b0 ready", 64'(w.mem_ready_o), 64'd1);
    @(negedge clk);
    idle();
    #1;
    chk("b2b1 we",    64'(w.we_o),    64'd1);
    chk("b2b1 waddr", 64'(w.waddr_o), 64'd6);
    chk("b2b1 wdata", w.wdata_o,      64'hFFFF_FFFF_FFFF_FFFF);
    chk("b2b1 cpc",   w.commit_pc_o,  64'h104);
    chk("b2b1 cnt",   w.commit_cnt_o, 64'd1);
    @(negedge clk);
    #1;
    chk("b2b2 cvalid", 64'(w.commit_valid_o), 64'd0);
    chk("b2b2 we",     64'(w.we_o),           64'd0);
    chk("b2b2 cnt",    w.commit_cnt_o,        64'd2);

    // load extraction
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      offer(64'h200 + 64'(i * 4), 32'h0000_3003, 1'b1, 5'd10, {61'h200, ld_off[i]},
            1'b1, ld_f3[i], RDATA);
      @(negedge clk);
      idle();
      #1;
      chk($sformatf("load%0d we", i),    64'(w.we_o),    64'd1);
      chk($sformatf("load%0d wdata", i), w.wdata_o,      ld_exp[i]);
      chk($sformatf("load%0d cnt", i),   w.commit_cnt_o, 64'(2 + i));
    end

    // x0 suppression
    @(negedge clk);
    offer(64'h300, ADDI, 1'b1, 5'd0, 64'hDEAD, 1'b0, 3'd0, 64'h0);
    @(negedge clk);
    idle();
    #1;
    chk("x0 we",     64'(w.we_o),           64'd0);
    chk("x0 cvalid", 64'(w.commit_valid_o), 64'd1);
    chk("x0 wdata",  w.wdata_o,             64'hDEAD);
    chk("x0 cnt",    w.commit_cnt_o,        64'd8);
    @(negedge clk);
    #1;
    chk("x0 cnt after", w.commit_cnt_o, 64'd9);

    // back-pressure with a second instruction pending
    @(negedge clk);
    offer(64'h400, ADDI, 1'b1, 5'd7, 64'hA, 1'b0, 3'd0, 64'h0);
    @(negedge clk);
    w.diff_ready_i = 1'b0;
    offer(64'h404, ADDI, 1'b1, 5'd8, 64'hB, 1'b0, 3'd0, 64'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d ready", c),  64'(w.mem_ready_o),    64'd0);
      chk($sformatf("stall%0d we", c),     64'(w.we_o),           64'd0);
      chk($sformatf("stall%0d cvalid", c), 64'(w.commit_valid_o), 64'd1);
      chk($sformatf("stall%0d cpc", c),    w.commit_pc_o,         64'h400);
      chk($sformatf("stall%0d wdata", c),  w.wdata_o,             64'hA);
      chk($sformatf("stall%0d cnt", c),    w.commit_cnt_o,        64'd9);
      @(negedge clk);
    end
    w.diff_ready_i = 1'b1;
    #1;
    chk("release we",    64'(w.we_o),        64'd1);
    chk("release waddr", 64'(w.waddr_o),     64'd7);
    chk("release ready", 64'(w.mem_ready_o), 64'd1);
    @(negedge clk);
    idle();
    #1;
    chk("second we",    64'(w.we_o),    64'd1);
    chk("second waddr", 64'(w.waddr_o), 64'd8);
    chk("second cpc",   w.commit_pc_o,  64'h404);
    chk("second cnt",   w.commit_cnt_o, 64'd10);
    @(negedge clk);
    #1;
    chk("bp cnt",    w.commit_cnt_o,        64'd11);
    chk("bp cvalid", 64'(w.commit_valid_o), 64'd0);

    // ebreak with another instruction queued behind it
    @(negedge clk);
    offer(64'h500, EBREAK, 1'b0, 5'd0, 64'h0, 1'b0, 3'd0, 64'h0);
    @(negedge clk);
    offer(64'h504, ADDI, 1'b1, 5'd9, 64'h99, 1'b0, 3'd0, 64'h0);
    #1;
    chk("ebrk cvalid", 64'(w.commit_valid_o), 64'd1);
    chk("ebrk cinst",  64'(w.commit_inst_o),  64'(EBREAK));
    chk("ebrk ready",  64'(w.mem_ready_o),    64'd0);
    chk("ebrk halt",   64'(w.halt_o),         64'd0);
    chk("ebrk cnt",    w.commit_cnt_o,        64'd11);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("halted%0d halt", c),   64'(w.halt_o),         64'd1);
      chk($sformatf("halted%0d ready", c),  64'(w.mem_ready_o),    64'd0);
      chk($sformatf("halted%0d cvalid", c), 64'(w.commit_valid_o), 64'd0);
      chk($sformatf("halted%0d we", c),     64'(w.we_o),           64'd0);
      chk($sformatf("halted%0d cnt", c),    w.commit_cnt_o,        64'd12);
    end

    // leave HALTED, then async reset while FULL and stalled
    @(negedge clk);
    idle();
    rst = 1'b1;
    #1;
    chk("unhalt halt", 64'(w.halt_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    offer(64'h600, ADDI, 1'b1, 5'd10, 64'h77, 1'b0, 3'd0, 64'h0);
    @(negedge clk);
    idle();
    w.diff_ready_i = 1'b0;
    #1;
    chk("pre-rst cvalid", 64'(w.commit_valid_o), 64'd1);
    chk("pre-rst cpc",    w.commit_pc_o,          64'h600);
    #1;
    rst = 1'b1;
    #1;
    chk_zero_outputs("async rst");
    @(negedge clk);
    rst = 1'b0;
    w.diff_ready_i = 1'b1;
    #1;
    chk("post-rst we",     64'(w.we_o),           64'd0);
    chk("post-rst cvalid", 64'(w.commit_valid_o), 64'd0);
    @(negedge clk);
    #1;
    chk("post-rst we2",  64'(w.we_o),    64'd0);
    chk("post-rst cnt2", w.commit_cnt_o, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
